apb_master_interface: RTL
=========================

// Module: apb_master_interface
// PURPOSE
//   APB requester that drives the register map of apb_slave_interface (transmit, FIFO, status,
//   slave address, command, prescale). Accepts one read/write command at a time on a
//   valid/ready host port, runs the APB SETUP and ACCESS phases, waits on PREADY with a
//   timeout, and returns a one-cycle response carrying read data or a timeout flag.
// PARAMETERS
//   DATA_WIDTH      8   width of pwdata_o, prdata_i, cmd_wdata_i, rsp_rdata_o
//   ADDR_WIDTH      8   width of paddr_o, cmd_addr_i
//   TIMEOUT_CYCLES  16  max ACCESS cycles waiting on pready_i; 0 disables timeout; range 0..65535
// PORTS
//   pclk_i        in   1           clock, all logic on rising edge
//   preset_ni     in   1           asynchronous active-low reset
//   cmd_valid_i   in   1           host command valid
//   cmd_ready_o   out  1           master can accept a command (high only in IDLE)
//   cmd_write_i   in   1           1 = write, 0 = read
//   cmd_addr_i    in   ADDR_WIDTH  target register address
//   cmd_wdata_i   in   DATA_WIDTH  write data (ignored for reads)
//   rsp_valid_o   out  1           one-cycle pulse: transfer finished
//   rsp_rdata_o   out  DATA_WIDTH  read data; valid with rsp_valid_o on reads
//   rsp_timeout_o out  1           qualifies rsp_valid_o: transfer aborted by timeout
//   paddr_o       out  ADDR_WIDTH  APB address
//   pwrite_o      out  1           APB direction
//   psel_o        out  1           APB select
//   penable_o     out  1           APB enable
//   pwdata_o      out  DATA_WIDTH  APB write data
//   prdata_i      in   DATA_WIDTH  APB read data
//   pready_i      in   1           APB ready
// BEHAVIOUR
//   Reset: state IDLE; psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o,
//     rsp_rdata_o, rsp_timeout_o, wait counter all 0; cmd_ready_o = 1 once out of reset.
//   All outputs registered except cmd_ready_o = (state == IDLE).
//   IDLE: cmd_valid_i & cmd_ready_o at edge -> latch addr/write/wdata into paddr_o/pwrite_o/
//     pwdata_o, go SETUP (psel_o=1, penable_o=0). cmd_valid_i outside IDLE ignored; host holds.
//   SETUP: exactly one cycle -> ACCESS (psel_o=1, penable_o=1), wait counter cleared.
//   ACCESS: pready_i=1 at edge -> IDLE, psel_o=penable_o=0, rsp_valid_o=1 for one cycle,
//     rsp_timeout_o=0, rsp_rdata_o<=prdata_i on reads (unchanged on writes).
//     pready_i=0 -> counter+1 (16-bit, saturating); if TIMEOUT_CYCLES!=0 and counter ==
//     TIMEOUT_CYCLES-1 at that edge -> IDLE, rsp_valid_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
//   pready_i and timeout on the same edge: pready_i wins (normal completion).
//   paddr_o/pwrite_o/pwdata_o stable from SETUP through ACCESS; hold last value in IDLE.
//   Latency: accept edge -> rsp_valid_o high after 3 edges with zero wait states; +1 per wait.
//   Throughput: one transfer per 3 cycles min; psel_o low exactly 1 cycle between back-to-back.
//   rsp_valid_o may coincide with acceptance of the next command (same IDLE cycle).
//   No rsp backpressure: host must consume rsp_valid_o pulse in the cycle it is high.
//   Reset mid-transfer: psel_o/penable_o drop immediately (async), no response issued.
// TESTING
//   1 Reset: preset_ni=0 mid-run -> all outputs 0; after release cmd_ready_o=1, psel_o=0.
//   2 Write addr 0x04 data 0x5A, pready_i=1 -> psel_o@+1, penable_o@+2, rsp_valid_o@+3,
//     paddr_o=0x04, pwdata_o=0x5A, pwrite_o=1 throughout, rsp_timeout_o=0.
//   3 Read addr 0x02, prdata_i=0xC3, pready_i low 2 ACCESS cycles -> 3 ACCESS cycles,
//     rsp_valid_o@+5 with rsp_rdata_o=0xC3, rsp_timeout_o=0.
//   4 pready_i stuck 0, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, then rsp_valid_o=1,
//     rsp_timeout_o=1, rsp_rdata_o=0, psel_o=0, cmd_ready_o=1.
//   5 cmd_valid_i held for write 0x05<-0x10 then read 0x05, pready_i=1 -> transfers 3 cycles
//     apart, psel_o low 1 cycle between, read returns 0x10 (against apb_slave_interface).
//   6 preset_ni pulsed low during ACCESS -> psel_o/penable_o 0 at once, no rsp_valid_o;
//     next command completes normally.

Source files
------------

// File: rtl/apb_master_interface.sv
// ---------------------------------------------------------------------------
// apb_master_interface
//   APB requester. Accepts one read/write command at a time on a valid/ready
//   host port, runs the APB SETUP and ACCESS phases, and waits on pready_i.
//   The wait is bounded by TIMEOUT_CYCLES (0 = wait forever). Completion is
//   reported with a one-cycle response pulse that carries either read data or
//   a timeout flag.
//
// Ports
//   pclk_i, preset_ni       clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o host command handshake (ready only in IDLE)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i   command contents
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             read data (zero on timeout, unchanged on writes)
//   rsp_timeout_o           the transfer was aborted by the timeout
//   paddr_o, pwrite_o, psel_o, penable_o, pwdata_o   APB request
//   prdata_i, pready_i      APB completer response
// ---------------------------------------------------------------------------
module apb_master_interface #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [15:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_e                r_state;
  logic [15:0]           r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic                  r_psel;
  logic                  r_penable;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_timeout;

  logic w_timeout_hit;

  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state       <= StIdle;
      r_wait_cnt    <= '0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            r_paddr  <= cmd_addr_i;
            r_pwrite <= cmd_write_i;
            r_pwdata <= cmd_wdata_i;
            r_psel   <= 1'b1;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= StAccess;
        end
        StAccess: begin
          // pready_i takes priority over a timeout on the same edge.
          if (pready_i) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            if (!r_pwrite) begin
              r_rsp_rdata <= prdata_i;
            end
            r_state <= StIdle;
          end else begin
            if (r_wait_cnt != 16'hFFFF) begin
              r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout_hit) begin
              r_psel        <= 1'b0;
              r_penable     <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_rdata   <= '0;
              r_state       <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o   = (r_state == StIdle);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_timeout_o = r_rsp_timeout;
  assign paddr_o       = r_paddr;
  assign pwrite_o      = r_pwrite;
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign pwdata_o      = r_pwdata;

endmodule
